// File: rtl/exec_pkg.sv
// exec_pkg
// Shared types and defaults for the multi-cycle execute stage.
//   op_t    : 5-bit ALU opcode; codes above OP_ASR behave as NOP.
//   state_t : sequencing FSM states for multi-cycle operations.
//   DEF_XLEN, DEF_MUL_LAT : default datapath width and multiply latency.
package exec_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_MUL_LAT = 3;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3,
        OP_MOD = 5'd4,
        OP_CMP = 5'd5,
        OP_AND = 5'd6,
        OP_OR  = 5'd7,
        OP_NOT = 5'd8,
        OP_MOV = 5'd9,
        OP_LSL = 5'd10,
        OP_LSR = 5'd11,
        OP_ASR = 5'd12
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIVI = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/div_iter.sv
// div_iter
// Iterative signed restoring divider, one quotient bit per cycle.
//   clk, rst       : clock, synchronous active-low reset
//   start          : latch operands and begin (ignored while abort is high)
//   abort          : drop any division in progress
//   dividend       : signed dividend
//   divisor        : signed divisor
//   done           : high in the final iteration cycle (XLEN cycles after start)
//   quotient       : signed quotient, truncated toward zero (valid with done)
//   remainder      : signed remainder, sign of dividend (valid with done)
// Divide by zero yields quotient all-ones and remainder equal to the dividend.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic            running;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] dividend_q;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_n;

    // One restoring step on magnitudes. The final step's result is exposed
    // combinationally so the caller can register it in the same cycle.
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs};
        rem_n  = rem_sh[XLEN-1:0];
        quo_n  = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b1};
        end
    end

    // Sign fix-up; INT_MIN / -1 falls out naturally as INT_MIN rem 0.
    always_comb begin
        done      = running && (cnt == CW'(1));
        quotient  = neg_q ? -quo_n : quo_n;
        remainder = neg_r ? -rem_n : rem_n;
        if (div_zero) begin
            quotient  = '1;
            remainder = dividend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            running    <= 1'b0;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            dividend_q <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running    <= 1'b1;
            cnt        <= CW'(XLEN);
            rem        <= '0;
            quo        <= dividend[XLEN-1] ? -dividend : dividend;
            dvs        <= divisor[XLEN-1] ? -divisor : divisor;
            dividend_q <= dividend;
            neg_q      <= dividend[XLEN-1] ^ divisor[XLEN-1];
            neg_r      <= dividend[XLEN-1];
            div_zero   <= (divisor == '0);
        end else if (running) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc
// Execute stage with operand forwarding, ALU/compare/branch resolution,
// multi-cycle MUL/DIV/MOD and an elastic EX/MEM output buffer.
//   clk, rst                 : clock, synchronous active-low reset
//   flush                    : kill the accepting or in-flight instruction
//   in_valid / in_ready      : handshake with decode
//   in_pc, in_a, in_b        : pc and operands (B already has imm muxed in)
//   in_rd2, in_target        : store data and branch target
//   in_op                    : opcode (exec_pkg::op_t)
//   in_fsel_a/_b/_st         : forward select, 0 = own value, k = source k-1
//   fwd_data                 : forwarding sources, source k at [k*XLEN +: XLEN]
//   in_is_ret/beq/bgt/ub     : branch class
//   in_ctrl                  : opaque control passed through to MEM
//   br_taken, pc_branch      : branch resolution in the accept cycle
//   busy                     : multi-cycle operation in flight
//   out_valid / out_ready    : handshake with MEM
//   out_pc, out_result, out_rd2, out_ctrl : registered EX/MEM buffer
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int  XLEN    = DEF_XLEN,
    parameter int  NFWD    = 3,
    parameter int  CTRLW   = 12,
    parameter int  MUL_LAT = DEF_MUL_LAT,
    localparam int FSW     = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [XLEN-1:0]      in_rd2,
    input  logic [XLEN-1:0]      in_target,
    input  logic [4:0]           in_op,
    input  logic [FSW-1:0]       in_fsel_a,
    input  logic [FSW-1:0]       in_fsel_b,
    input  logic [FSW-1:0]       in_fsel_st,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 in_is_ret,
    input  logic                 in_is_beq,
    input  logic                 in_is_bgt,
    input  logic                 in_is_ub,
    input  logic [CTRLW-1:0]     in_ctrl,
    output logic                 br_taken,
    output logic [XLEN-1:0]      pc_branch,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_result,
    output logic [XLEN-1:0]      out_rd2,
    output logic [CTRLW-1:0]     out_ctrl
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

    state_t state, state_n;

    logic [XLEN-1:0]  fa, fb, fst, alu_res;
    logic [SHW-1:0]   shamt;
    logic             free, accept, load, is_mul, is_div;
    logic             gt_flag, eq_flag;
    logic [CW-1:0]    mul_cnt;
    logic [XLEN-1:0]  hold_pc, hold_res, hold_rd2;
    logic [CTRLW-1:0] hold_ctrl;
    logic             hold_is_mod;
    logic [XLEN-1:0]  load_pc, load_res, load_rd2;
    logic [CTRLW-1:0] load_ctrl;
    logic             div_start, div_done;
    logic [XLEN-1:0]  div_q, div_r, div_sel;

    function automatic logic [XLEN-1:0] pick(input logic [FSW-1:0]       sel,
                                             input logic [XLEN-1:0]      own,
                                             input logic [NFWD*XLEN-1:0] fwd);
        logic [XLEN-1:0] r;
        r = own;
        for (int k = 1; k <= NFWD; k++) begin
            if (sel == FSW'(k)) begin
                r = fwd[(k-1)*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    assign fa    = pick(in_fsel_a, in_a, fwd_data);
    assign fb    = pick(in_fsel_b, in_b, fwd_data);
    assign fst   = pick(in_fsel_st, in_rd2, fwd_data);
    assign shamt = fb[SHW-1:0];

    assign free      = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && free;
    assign accept    = in_valid && in_ready && !flush;
    assign busy      = (state != IDLE);
    assign is_mul    = (in_op == OP_MUL);
    assign is_div    = (in_op == OP_DIV) || (in_op == OP_MOD);
    assign div_sel   = hold_is_mod ? div_r : div_q;

    // Flags are the registered values, so a CMP accepted one cycle earlier is visible.
    assign br_taken  = accept && (in_is_ub || (in_is_beq && eq_flag) || (in_is_bgt && gt_flag));
    assign pc_branch = in_is_ret ? fa : in_target;

    // Single-cycle results; multi-cycle ops, CMP and NOP codes produce 0 here.
    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = fa + fb;
            OP_SUB:  alu_res = fa - fb;
            OP_AND:  alu_res = fa & fb;
            OP_OR:   alu_res = fa | fb;
            OP_NOT:  alu_res = ~fa;
            OP_MOV:  alu_res = fb;
            OP_LSL:  alu_res = fa << shamt;
            OP_LSR:  alu_res = fa >> shamt;
            OP_ASR:  alu_res = $signed(fa) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Sequencing and buffer-load selection. Flush discards in-flight work
    // before any load decision is made.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        div_start = 1'b0;
        load_pc   = hold_pc;
        load_rd2  = hold_rd2;
        load_ctrl = hold_ctrl;
        load_res  = hold_res;
        case (state)
            IDLE: begin
                load_pc   = in_pc;
                load_rd2  = fst;
                load_ctrl = in_ctrl;
                load_res  = alu_res;
                if (accept) begin
                    if (is_mul) begin
                        state_n = MULT;
                    end else if (is_div) begin
                        state_n   = DIVI;
                        div_start = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MULT: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (mul_cnt == '0) begin
                    load    = free;
                    state_n = free ? IDLE : WAIT;
                end
            end
            DIVI: begin
                load_res = div_sel;
                if (flush) begin
                    state_n = IDLE;
                end else if (div_done) begin
                    load    = free;
                    state_n = free ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (free) begin
                    load    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            gt_flag     <= 1'b0;
            eq_flag     <= 1'b0;
            mul_cnt     <= '0;
            hold_pc     <= '0;
            hold_res    <= '0;
            hold_rd2    <= '0;
            hold_ctrl   <= '0;
            hold_is_mod <= 1'b0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_result  <= '0;
            out_rd2     <= '0;
            out_ctrl    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                hold_pc     <= in_pc;
                hold_rd2    <= fst;
                hold_ctrl   <= in_ctrl;
                hold_is_mod <= (in_op == OP_MOD);
                hold_res    <= fa * fb;
                mul_cnt     <= CW'(MUL_LAT - 2);
                if (in_op == OP_CMP) begin
                    gt_flag <= ($signed(fa) > $signed(fb));
                    eq_flag <= (fa == fb);
                end
            end
            if (state == MULT && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - CW'(1);
            end
            // Park the quotient/remainder when MEM is stalled at completion.
            if (state == DIVI && div_done) begin
                hold_res <= div_sel;
            end
            if (load) begin
                out_valid  <= 1'b1;
                out_pc     <= load_pc;
                out_result <= load_res;
                out_rd2    <= load_rd2;
                out_ctrl   <= load_ctrl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (fa),
        .divisor   (fb),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

endmodule
